vector_writeback_unit: RTL and testbench
========================================

Name: vector_writeback_unit

Overview:
Write-side front end for the 8x32-bit vector register file. It buffers execute-stage results in a small FIFO and merges partial byte-lane writes with the current register contents (read-modify-write through one register-file read port). It then drives the register file's single write port, one write per cycle. It also exports a pending-write scoreboard so issue logic can stall on RAW hazards.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
AW, 3, register address width (8 registers)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous; discard all FIFO entries
stall  input  1  write port borrowed elsewhere; no pop this cycle
in_valid  input  1  result valid
in_ready  output  1  FIFO can accept
in_addr  input  AW  destination register
in_data  input  32  result data
in_mask  input  4  byte-lane enables; bit i covers data[8i+7:8i]
rf_rd_addr  output  AW  to register-file read port (combinational = head addr)
rf_rd_data  input  32  register-file read data (combinational read)
rf_we  output  1  registered write enable to register file
rf_waddr  output  AW  registered write address
rf_wdata  output  32  registered write data
pending  output  8  bit r set while a write to register r is queued or in flight
empty  output  1  FIFO empty and rf_we low

Behaviour:
- Reset (async assert): FIFO count/pointers 0, rf_we=0, rf_waddr=0, rf_wdata=0. Consequently pending=0, empty=1, in_ready=1. Any in-flight write is abandoned.
- Push: when in_valid && in_ready, store {addr,data,mask} at tail.
- in_ready = (count != DEPTH), computed from registered count only. A pop in the same cycle does not raise in_ready.
- Pop condition: count!=0 && !stall && !flush. Pop at most one entry per cycle.
- Merge on pop:
  - old = (rf_we && rf_waddr==head.addr) ? rf_wdata : rf_rd_data. This bypass covers a back-to-back write to the same register that has not yet been committed.
  - merged byte i = head.mask[i] ? head.data byte i : old byte i.
- Output register update each edge:
  - Popped entry with mask!=0: rf_we=1, rf_waddr=head.addr, rf_wdata=merged.
  - Popped entry with mask==0: consumed silently, rf_we=0.
  - Otherwise: rf_we=0, rf_waddr/rf_wdata hold.
- Latency: entry accepted at edge E into empty FIFO with stall low gives rf_we high in the cycle after edge E+1. The register file commits at edge E+2. There is no input-to-output bypass.
- Throughput: one write per cycle sustained.
- stall: freezes the FIFO head; rf_we drops to 0 at the next edge. Pushes continue until full.
- flush:
  - Count and pointers return to 0 at the edge.
  - A push in the same cycle is dropped.
  - rf_we is forced to 0 at the next edge, but a write already presented on rf_we this cycle still commits.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance modulo DEPTH.
- pending:
  - OR of one-hot(addr) over all valid FIFO entries with mask!=0, plus one-hot(rf_waddr) when rf_we=1.
  - Purely combinational from registered state.
- empty = (count==0) && !rf_we.

Test Plan:
- Full-mask write: regfile r2=05060708; push addr=2, data=AABBCCDD, mask=F -> rf_we=1, rf_waddr=2, rf_wdata=AABBCCDD two edges after the push; pending[2] high from the cycle after the push until rf_we drops.
- Partial merge: r1=01020304; push addr=1, data=FFFFFFFF, mask=0101 -> rf_wdata=01FF03FF.
- Back-to-back same register: r3=0C0B0A09; push addr=3 data=000000AA mask=0001, then next cycle addr=3 data=0000BB00 mask=0010 -> writes 0C0B0AAA then 0C0BBBAA on consecutive cycles (bypass exercised).
- Stall/full: hold stall=1 and push 5 entries -> in_ready low after 4 accepts, 5th held off. Release stall -> 4 writes in 4 consecutive cycles in push order, then in_ready returns high.
- Mask zero and flush: push addr=5 mask=0 -> no rf_we, pending[5] never set. Queue 3 entries under stall, assert flush 1 cycle -> count=0, no writes issued, pending=0, empty=1.
- Async reset mid-operation: assert rst between clock edges while rf_we=1 and count=2 -> rf_we, pending and count clear immediately (before the next edge), in_ready=1, no further writes after release.

Source files
------------

// File: rtl/vector_writeback_unit_if.sv
// Bus bundle for the vector write-back unit: execute-side push channel,
// register-file read/write ports and hazard/status outputs.
interface vector_writeback_unit_if #(
  parameter int AW = 3
);
  logic                 flush;
  logic                 stall;
  logic                 in_valid;
  logic                 in_ready;
  logic [AW-1:0]        in_addr;
  logic [31:0]          in_data;
  logic [3:0]           in_mask;
  logic [AW-1:0]        rf_rd_addr;
  logic [31:0]          rf_rd_data;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [31:0]          rf_wdata;
  logic [(1<<AW)-1:0]   pending;
  logic                 empty;

  modport master (
    output flush, stall, in_valid, in_addr, in_data, in_mask, rf_rd_data,
    input  in_ready, rf_rd_addr, rf_we, rf_waddr, rf_wdata, pending, empty
  );

  modport slave (
    input  flush, stall, in_valid, in_addr, in_data, in_mask, rf_rd_data,
    output in_ready, rf_rd_addr, rf_we, rf_waddr, rf_wdata, pending, empty
  );
endinterface

// File: rtl/vector_writeback_unit.sv
// Vector register-file write-back front end: result FIFO, byte-lane
// read-modify-write merge with same-register bypass, and RAW scoreboard.
module vector_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  vector_writeback_unit_if.slave  bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int NREG = 1 << AW;

  logic [AW-1:0]  addr_mem [DEPTH];
  logic [31:0]    data_mem [DEPTH];
  logic [3:0]     mask_mem [DEPTH];

  logic [PW-1:0]  head_p0;
  logic [PW-1:0]  tail_p0;
  logic [CW-1:0]  count_p0;

  logic           vld_p1;
  logic [AW-1:0]  waddr_p1;
  logic [31:0]    wdata_p1;

  logic           full;
  logic           push;
  logic           pop;
  logic [AW-1:0]  head_addr;
  logic [31:0]    head_data;
  logic [3:0]     head_mask;
  logic [31:0]    old_word;
  logic [31:0]    merged;
  logic [NREG-1:0] pend;
  logic [PW-1:0]  idx;

  function automatic logic [31:0] merge_lanes(input logic [31:0] new_word,
                                              input logic [31:0] old_w,
                                              input logic [3:0]  lane_en);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

  assign full          = (count_p0 == CW'(DEPTH));
  assign bus.in_ready  = !full;
  assign push          = bus.in_valid && !full && !bus.flush;
  assign pop           = (count_p0 != '0) && !bus.stall && !bus.flush;

  assign head_addr      = addr_mem[head_p0];
  assign head_data      = data_mem[head_p0];
  assign head_mask      = mask_mem[head_p0];
  assign bus.rf_rd_addr = head_addr;

  // The previous write may not have committed yet, so it overrides the RF read.
  assign old_word = (vld_p1 && (waddr_p1 == head_addr)) ? wdata_p1 : bus.rf_rd_data;
  assign merged   = merge_lanes(head_data, old_word, head_mask);

  // ---- stage p0: FIFO storage and pointers ----
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_p0] <= bus.in_addr;
      data_mem[tail_p0] <= bus.in_data;
      mask_mem[tail_p0] <= bus.in_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
    end else if (bus.flush) begin
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
    end else begin
      if (push) tail_p0 <= tail_p0 + 1'b1;
      if (pop)  head_p0 <= head_p0 + 1'b1;
      case ({push, pop})
        2'b10:   count_p0 <= count_p0 + 1'b1;
        2'b01:   count_p0 <= count_p0 - 1'b1;
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // ---- stage p1: registered write port ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else if (pop && (head_mask != 4'b0000)) begin
      vld_p1   <= 1'b1;
      waddr_p1 <= head_addr;
      wdata_p1 <= merged;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.rf_we    = vld_p1;
  assign bus.rf_waddr = waddr_p1;
  assign bus.rf_wdata = wdata_p1;

  // Zero-mask entries never write, so they never block issue.
  always_comb begin
    pend = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_p0 + PW'(i);
      if ((CW'(i) < count_p0) && (mask_mem[idx] != 4'b0000)) pend[addr_mem[idx]] = 1'b1;
    end
    if (vld_p1) pend[waddr_p1] = 1'b1;
  end

  assign bus.pending = pend;
  assign bus.empty   = (count_p0 == '0) && !vld_p1;

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Bench for vector_writeback_unit: directed scenarios plus random traffic,
// checked against a queue-based architectural model of in-order masked writes.
module tb_vector_writeback_unit;
  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_writeback_unit_if #(.AW(AW)) bus();

  vector_writeback_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] rf [8];
  assign bus.rf_rd_data = rf[bus.rf_rd_addr];

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  ent_t        fifo_q[$];
  logic [31:0] arch [8];
  logic        exp_we;
  logic [2:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_prev;
  int          n_assert;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_mask(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  m);
    logic [31:0] lm;
    lm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (new_w & lm) | (old_w & ~lm);
  endfunction

  function automatic logic [7:0] model_pending();
    logic [7:0] p;
    p = 8'h00;
    foreach (fifo_q[i]) if (fifo_q[i].mask != 4'h0) p = p | (8'h01 << fifo_q[i].addr);
    if (exp_we) p = p | (8'h01 << exp_waddr);
    return p;
  endfunction

  task automatic model_reset();
    if (exp_we) arch[exp_waddr] = exp_prev;
    fifo_q.delete();
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  task automatic check_all();
    chk("rf_we",    32'(bus.rf_we),    32'(exp_we));
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(exp_waddr));
    chk("rf_wdata", bus.rf_wdata,      exp_wdata);
    chk("in_ready", 32'(bus.in_ready), 32'(fifo_q.size() < DEPTH));
    chk("pending",  32'(bus.pending),  32'(model_pending()));
    chk("empty",    32'(bus.empty),    32'(fifo_q.size() == 0 && !exp_we));
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_mask  = m;
  endtask

  task automatic preload(input logic [2:0] a, input logic [31:0] v);
    rf[a]   = v;
    arch[a] = v;
  endtask

  // One clock: predict from pre-edge inputs, let the edge happen, commit RF, check.
  task automatic step();
    int          sz;
    logic        do_pop, do_push, do_flush, cwe;
    logic [2:0]  ca;
    logic [31:0] cd;
    ent_t        pe, e;
    sz       = fifo_q.size();
    do_flush = bus.flush;
    do_pop   = (sz != 0) && !bus.stall && !do_flush;
    do_push  = bus.in_valid && (sz < DEPTH) && !do_flush;
    pe.addr  = bus.in_addr;
    pe.data  = bus.in_data;
    pe.mask  = bus.in_mask;
    cwe      = bus.rf_we;
    ca       = bus.rf_waddr;
    cd       = bus.rf_wdata;
    @(posedge clk);
    #1;
    if (cwe) rf[ca] = cd;
    exp_we = 1'b0;
    if (do_flush) begin
      fifo_q.delete();
    end else begin
      if (do_pop) begin
        e = fifo_q.pop_front();
        if (e.mask != 4'h0) begin
          exp_we    = 1'b1;
          exp_waddr = e.addr;
          exp_prev  = arch[e.addr];
          exp_wdata = apply_mask(arch[e.addr], e.data, e.mask);
          arch[e.addr] = exp_wdata;
        end
      end
      if (do_push) fifo_q.push_back(pe);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) preload(3'(i), $urandom);
    exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; exp_prev = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();

    // Full-mask write
    preload(3'd2, 32'h05060708);
    drive(1'b1, 3'd2, 32'hAABBCCDD, 4'hF);
    step();
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    chk("t1_pending2", 32'(bus.pending[2]), 32'd1);
    step();
    chk("t1_we", 32'(bus.rf_we), 32'd1);
    chk("t1_waddr", 32'(bus.rf_waddr), 32'd2);
    chk("t1_wdata", bus.rf_wdata, 32'hAABBCCDD);
    step();
    chk("t1_pending_clr", 32'(bus.pending), 32'd0);
    chk("t1_rf2", rf[2], 32'hAABBCCDD);

    // Partial merge
    preload(3'd1, 32'h01020304);
    drive(1'b1, 3'd1, 32'hFFFFFFFF, 4'b0101);
    step();
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    step();
    chk("t2_wdata", bus.rf_wdata, 32'h01FF03FF);
    step();

    // Back-to-back same register exercises the bypass
    preload(3'd3, 32'h0C0B0A09);
    drive(1'b1, 3'd3, 32'h000000AA, 4'b0001);
    step();
    drive(1'b1, 3'd3, 32'h0000BB00, 4'b0010);
    step();
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    chk("t3_first", bus.rf_wdata, 32'h0C0B0AAA);
    step();
    chk("t3_second", bus.rf_wdata, 32'h0C0BBBAA);
    chk("t3_second_we", 32'(bus.rf_we), 32'd1);
    step();
    chk("t3_rf3", rf[3], 32'h0C0BBBAA);

    // Stall until full, then drain in order
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'(k), $urandom, 4'hF);
      step();
    end
    chk("t4_full_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    bus.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_drain_we", 32'(bus.rf_we), 32'd1);
      chk("t4_drain_addr", 32'(bus.rf_waddr), 32'(k));
    end
    chk("t4_ready_back", 32'(bus.in_ready), 32'd1);
    step();

    // Zero mask is consumed silently
    drive(1'b1, 3'd5, 32'h12345678, 4'h0);
    step();
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    chk("t5_pend5_q", 32'(bus.pending[5]), 32'd0);
    step();
    chk("t5_no_we", 32'(bus.rf_we), 32'd0);
    step();

    // Flush discards queued entries
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'(k + 4), $urandom, 4'hF);
      step();
    end
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    chk("t6_empty", 32'(bus.empty), 32'd1);
    chk("t6_pending", 32'(bus.pending), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_we", 32'(bus.rf_we), 32'd0);
    end

    // Async reset with a write in flight and two entries queued
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'(k + 1), $urandom, 4'hF);
      step();
    end
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    bus.stall = 1'b0;
    step();
    chk("t7_inflight", 32'(bus.rf_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t7_we_clr", 32'(bus.rf_we), 32'd0);
    chk("t7_pend_clr", 32'(bus.pending), 32'd0);
    chk("t7_ready", 32'(bus.in_ready), 32'd1);
    chk("t7_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    for (int i = 0; i < 8; i++) chk("t7_rf", rf[i], arch[i]);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 29) == 0);
      step();
    end
    drive(1'b0, 3'd0, 32'h0, 4'h0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    for (int k = 0; k < 8; k++) step();
    for (int i = 0; i < 8; i++) chk("final_rf", rf[i], arch[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
